i2s_rx_frontend: RTL
====================

// Module: i2s_rx_frontend
// PURPOSE
//   Serial audio receiver feeding the lowpass FIR stage. Samples an external I2S link
//   (bclk/lrclk/sdata) in the master clock domain, deserialises each channel slot
//   MSB-first into an 18-bit two's-complement word, and presents it on dataout with a
//   one-cycle endata strobe that connects directly to lowpass.datain/endata.
// PARAMETERS
//   DATA_W   18  output word width; first DATA_W bits of each slot are kept
//   SLOT_W   32  nominal bclk periods per channel slot; bit counter saturates here
// PORTS
//   clock     in   1       master clock; must be >= 4x bclk frequency
//   reset     in   1       asynchronous, active-low master reset
//   enable    in   1       0: ignore the link, return to HUNT, no strobes
//   bclk_in   in   1       I2S bit clock, asynchronous to clock
//   lrclk_in  in   1       I2S word select, asynchronous; 0 = left, 1 = right
//   sdata_in  in   1       I2S serial data, asynchronous
//   dataout   out  DATA_W  last completed word, signed, held between strobes
//   endata    out  1       one-cycle strobe: dataout/chan valid this cycle
//   chan      out  1       channel of dataout (0 = left, 1 = right)
//   framerr   out  1       one-cycle pulse: slot shorter than DATA_W bits, word dropped
// BEHAVIOUR
//   - Reset (reset=0): dataout=0, endata=0, chan=0, framerr=0, counter=0, state=HUNT.
//     Asserting reset mid-slot discards the partial word; no strobe is produced.
//   - bclk_in, lrclk_in, sdata_in each pass through a 2-FF synchroniser. A bclk rising
//     edge (sync'd bclk 0->1) gives a one-cycle internal tick; lrclk and sdata are
//     sampled on the tick.
//   - FSM: HUNT -> SHIFT on the first tick where sampled lrclk differs from its previous
//     tick value (slot boundary). Partial slots after reset/enable are never output.
//   - SHIFT: I2S one-bit delay. The tick after a boundary carries the MSB. Ticks 1..DATA_W
//     shift sdata into a DATA_W shift register MSB-first; later ticks are ignored. The
//     counter saturates at SLOT_W.
//   - Slot boundary while in SHIFT: if count >= DATA_W, on the next clock load dataout
//     with the shift register, set chan = the previous lrclk value, pulse endata for
//     exactly 1 cycle. If count < DATA_W, pulse framerr, leave dataout/chan unchanged,
//     and issue no endata. In both cases clear the counter and stay in SHIFT.
//   - Latency: endata rises 4 clock cycles after the lrclk_in/bclk_in edge at the pins
//     (2 sync + 1 edge detect + 1 output register). Consecutive strobes are >= 1 slot apart.
//   - enable=0: FSM forced to HUNT and counter cleared. dataout/chan hold. No
//     endata/framerr. Re-enable waits for a fresh boundary.
//   - Boundary and bit sampled on the same tick: the boundary wins. That bit is the
//     delayed-LSB slot of the old word and is discarded.
// CONFIGURATION
//   I2S_RX_MONOMIX_EN defined: the left word is held internally and never strobed.
//     On right-word completion: dataout = (L + R) >>> 1, computed in DATA_W+1 bits as a
//     signed sum with arithmetic shift, truncating toward -inf. One endata per frame,
//     chan = 0. A framerr on either slot suppresses that frame's output.
//   Not defined: both channels are strobed separately as above, with chan set per word.
// TESTING
//   1 reset low mid-slot, release -> all outputs 0; no endata until 2nd lrclk boundary.
//   2 bclk = clock/8, SLOT_W=32, L=18'h2A5A5, R=18'h1FFFF -> endata with chan=0 and
//     dataout=18'h2A5A5, then chan=1 and dataout=18'h1FFFF; endata 4 clocks after lrclk edge.
//   3 slot of only 10 bclk periods -> framerr pulse, no endata, dataout keeps prior value.
//   4 negative full scale L=18'h20000 -> dataout=18'h20000, sign intact; 24-bit slot
//     with trailing bits 1 -> extra bits ignored.
//   5 enable dropped mid-slot then raised -> no strobe until 1st full slot after a new boundary.
//   6 MONOMIX_EN: L=18'h00003, R=18'h3FFFE (-2) -> single endata, dataout=18'h00000, chan=0;
//     L=R=18'h1FFFF -> dataout=18'h1FFFF (no overflow).

Source files
------------

// File: rtl/i2s_rx_frontend.sv
// I2S receiver front end: synchronises the link, deserialises each slot MSB-first into a
// DATA_W-bit signed word. Optional macro I2S_RX_MONOMIX_EN emits one (L+R)>>>1 word per frame.
module i2s_rx_frontend #(
    parameter int DATA_W = 18,
    parameter int SLOT_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     bclk_in,
    input  logic                     lrclk_in,
    input  logic                     sdata_in,
    output logic signed [DATA_W-1:0] dataout,
    output logic                     endata,
    output logic                     chan,
    output logic                     framerr
);

    localparam int CNT_W = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);

    typedef enum logic {HUNT, SHIFT} state_t;

    logic bclk_p0_q, bclk_p1_q, bclk_p2_q;
    logic lr_p0_q, lr_p1_q, sd_p0_q, sd_p1_q;
    logic tick_q, lr_t_q, sd_t_q;
    logic lr_last_q, lr_vld_q;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic signed [DATA_W-1:0] dataout_q, dataout_d;
    logic endata_q, endata_d, chan_q, chan_d, framerr_q, framerr_d;
    logic boundary, word_ok;

`ifdef I2S_RX_MONOMIX_EN
    logic [DATA_W-1:0] left_q, left_d;
    logic left_ok_q, left_ok_d;

    // Sum in DATA_W+1 bits; dropping the LSB is an arithmetic shift (floor).
    function automatic logic signed [DATA_W-1:0] mono_mix(input logic signed [DATA_W-1:0] l,
                                                         input logic signed [DATA_W-1:0] r);
        logic signed [DATA_W:0] sum;
        sum = $signed({l[DATA_W-1], l}) + $signed({r[DATA_W-1], r});
        return sum[DATA_W:1];
    endfunction
`endif

    // A boundary needs a valid previous lrclk sample, so the first tick after reset never counts.
    assign boundary = tick_q && lr_vld_q && (lr_t_q != lr_last_q);
    assign word_ok  = (cnt_q >= DATA_CNT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        dataout_d = dataout_q;
        chan_d    = chan_q;
        endata_d  = 1'b0;
        framerr_d = 1'b0;
`ifdef I2S_RX_MONOMIX_EN
        left_d    = left_q;
        left_ok_d = left_ok_q;
`endif
        if (!enable) begin
            state_d = HUNT;
            cnt_d   = '0;
`ifdef I2S_RX_MONOMIX_EN
            left_ok_d = 1'b0;
`endif
        end else if (tick_q) begin
            case (state_q)
                HUNT: begin
                    if (boundary) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
`ifdef I2S_RX_MONOMIX_EN
                        left_ok_d = 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (boundary) begin
                        cnt_d = '0;
                        if (!word_ok) begin
                            framerr_d = 1'b1;
`ifdef I2S_RX_MONOMIX_EN
                            left_ok_d = 1'b0;
`endif
                        end else begin
`ifdef I2S_RX_MONOMIX_EN
                            if (!lr_last_q) begin
                                left_d    = sr_q;
                                left_ok_d = 1'b1;
                            end else begin
                                if (left_ok_q) begin
                                    dataout_d = mono_mix(left_q, sr_q);
                                    chan_d    = 1'b0;
                                    endata_d  = 1'b1;
                                end
                                left_ok_d = 1'b0;
                            end
`else
                            dataout_d = sr_q;
                            chan_d    = lr_last_q;
                            endata_d  = 1'b1;
`endif
                        end
                    end else begin
                        if (cnt_q < DATA_CNT) sr_d = {sr_q[DATA_W-2:0], sd_t_q};
                        if (cnt_q < SLOT_CNT) cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bclk_p0_q <= 1'b0;
            bclk_p1_q <= 1'b0;
            bclk_p2_q <= 1'b0;
            lr_p0_q   <= 1'b0;
            lr_p1_q   <= 1'b0;
            sd_p0_q   <= 1'b0;
            sd_p1_q   <= 1'b0;
            tick_q    <= 1'b0;
            lr_t_q    <= 1'b0;
            sd_t_q    <= 1'b0;
            lr_last_q <= 1'b0;
            lr_vld_q  <= 1'b0;
            state_q   <= HUNT;
            cnt_q     <= '0;
            dataout_q <= '0;
            endata_q  <= 1'b0;
            chan_q    <= 1'b0;
            framerr_q <= 1'b0;
`ifdef I2S_RX_MONOMIX_EN
            left_ok_q <= 1'b0;
`endif
        end else begin
            bclk_p0_q <= bclk_in;
            bclk_p1_q <= bclk_p0_q;
            bclk_p2_q <= bclk_p1_q;
            lr_p0_q   <= lrclk_in;
            lr_p1_q   <= lr_p0_q;
            sd_p0_q   <= sdata_in;
            sd_p1_q   <= sd_p0_q;
            tick_q    <= bclk_p1_q & ~bclk_p2_q;
            lr_t_q    <= lr_p1_q;
            sd_t_q    <= sd_p1_q;
            if (tick_q) begin
                lr_last_q <= lr_t_q;
                lr_vld_q  <= 1'b1;
            end
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dataout_q <= dataout_d;
            endata_q  <= endata_d;
            chan_q    <= chan_d;
            framerr_q <= framerr_d;
`ifdef I2S_RX_MONOMIX_EN
            left_ok_q <= left_ok_d;
`endif
        end
    end

    // Word storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clock) begin
        sr_q <= sr_d;
`ifdef I2S_RX_MONOMIX_EN
        left_q <= left_d;
`endif
    end

    assign dataout = dataout_q;
    assign endata  = endata_q;
    assign chan    = chan_q;
    assign framerr = framerr_q;

endmodule
